// File: rtl/weight_bram_ctrl_if.sv
// Bundle of the weight BRAM controller's external channels.
//   ld_*     : host weight-load channel (valid/ready write requests)
//   rd_*     : burst-read command/status channel
//   out_*    : weight stream towards the PE array (valid/ready, FIFO head)
//   bram_*   : single-port weight BRAM, 1-cycle registered read
// Modports:
//   slave  : the controller side (weight_bram_ctrl)
//   master : the environment side (host, stream consumer, BRAM)
interface weight_bram_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    logic              rd_start;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W:0]   rd_len;
    logic              rd_busy;
    logic              rd_done;
    logic              rd_err;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    modport slave (
        input  ld_valid, ld_addr, ld_data,
        input  rd_start, rd_base, rd_len,
        input  out_ready,
        input  bram_dout,
        output ld_ready,
        output rd_busy, rd_done, rd_err,
        output out_valid, out_data, out_last,
        output bram_en, bram_we, bram_addr, bram_din
    );

    modport master (
        output ld_valid, ld_addr, ld_data,
        output rd_start, rd_base, rd_len,
        output out_ready,
        output bram_dout,
        input  ld_ready,
        input  rd_busy, rd_done, rd_err,
        input  out_valid, out_data, out_last,
        input  bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/weight_bram_ctrl.sv
// weight_bram_ctrl
// Arbitrates the single port of the weight BRAM between host weight loads
// and burst reads that stream weights to the systolic array through a
// 4-entry output FIFO with valid/ready backpressure.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : weight_bram_ctrl_if.slave (load, burst command/status, output
//          stream and BRAM port; see the interface file)
// Build option:
//   WBC_ADDR_WRAP_EN : when defined the burst address counter wraps modulo
//   the BRAM depth and any non-zero length is accepted; when undefined a
//   burst running past the top of memory is rejected with rd_err.
module weight_bram_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input logic            clk,
    input logic            rst,
    weight_bram_ctrl_if.slave bus
);

    localparam int FIFO_DEPTH = 4;
    localparam logic [ADDR_W+1:0] MEM_DEPTH = {2'b01, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W:0]   rem_cnt;

    logic              vld_p0;
    logic              last_p0;
    logic              vld_p1;
    logic              last_p1;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [1:0]        wptr;
    logic [1:0]        rptr;
    logic [2:0]        occ;
    logic [2:0]        used_slots;

    logic              push;
    logic              pop;
    logic              start_ok;
    logic              start_bad;
    logic              rd_err_q;

    logic              ld_ready_c;
    logic              bram_en_c;
    logic              bram_we_c;
    logic [ADDR_W-1:0] bram_addr_c;
    logic              out_valid_c;
    logic              out_last_c;

    // Non-zero length, and without wrap the burst must end at or below the
    // top of memory (base + len == depth is the last legal end point).
    function automatic logic req_legal(input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W:0]   len);
`ifdef WBC_ADDR_WRAP_EN
        return (len != '0);
`else
        logic [ADDR_W+1:0] span;
        span = {2'b00, base} + {1'b0, len};
        return (len != '0) && (span <= MEM_DEPTH);
`endif
    endfunction

    // Slots already committed: words in the FIFO plus the read whose data
    // arrives this cycle. Issuing only below FIFO_DEPTH means every issued
    // word has a FIFO slot reserved, even if the consumer stalls.
    assign used_slots = occ + {2'b00, vld_p1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        vld_p0      = 1'b0;
        last_p0     = 1'b0;
        start_ok    = 1'b0;
        start_bad   = 1'b0;
        ld_ready_c  = 1'b0;
        bram_en_c   = 1'b0;
        bram_we_c   = 1'b0;
        bram_addr_c = bus.ld_addr;
        case (state)
            IDLE: begin
                // A burst request wins a same-cycle collision with a load.
                ld_ready_c = !bus.rd_start;
                if (bus.rd_start) begin
                    if (req_legal(bus.rd_base, bus.rd_len)) begin
                        start_ok  = 1'b1;
                        state_nxt = BURST;
                    end else begin
                        start_bad = 1'b1;
                    end
                end else if (bus.ld_valid) begin
                    bram_en_c = 1'b1;
                    bram_we_c = 1'b1;
                end
            end
            BURST: begin
                if (used_slots < 3'(FIFO_DEPTH)) begin
                    vld_p0      = 1'b1;
                    last_p0     = (rem_cnt == (ADDR_W+1)'(1));
                    bram_en_c   = 1'b1;
                    bram_addr_c = addr_cnt;
                    if (last_p0) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_cnt <= '0;
        end else if (start_ok) begin
            rem_cnt <= bus.rd_len;
        end else if (vld_p0) begin
            rem_cnt <= rem_cnt - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start_ok) begin
            addr_cnt <= bus.rd_base;
        end else if (vld_p0) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
        end
    end

    // ---- p0 -> p1: read issued, BRAM data returns next cycle ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
        last_p1 <= last_p0;
    end

    // ---- p1 -> FIFO: returned word captured with its last tag ----
    assign push        = vld_p1;
    assign out_valid_c = (occ != 3'd0);
    assign pop         = out_valid_c && bus.out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr] <= bus.bram_dout;
            fifo_last[wptr] <= last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 2'd1;
            end
            if (pop) begin
                rptr <= rptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= start_bad;
        end
    end

    // Head is masked when empty so the stream reads zero out of reset
    // without having to clear the FIFO storage.
    assign out_last_c    = out_valid_c && fifo_last[rptr];

    assign bus.ld_ready  = ld_ready_c;
    assign bus.bram_en   = bram_en_c;
    assign bus.bram_we   = bram_we_c;
    assign bus.bram_addr = bram_addr_c;
    assign bus.bram_din  = bus.ld_data;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_valid_c ? fifo_data[rptr] : '0;
    assign bus.out_last  = out_last_c;
    assign bus.rd_busy   = (state != IDLE);
    assign bus.rd_done   = pop && out_last_c;
    assign bus.rd_err    = rd_err_q;

endmodule
